// File: rtl/scene_buffer_pkg.sv
// Shared types for the scene buffer: object record, vector type and bank depth.
package scene_buffer_pkg;

  localparam int SCENE_BUFFER_DEPTH = 16;

  typedef struct packed {
    logic [23:0] x;
    logic [23:0] y;
    logic [23:0] z;
  } fp24_vec3;

  // A zero radius makes an object non-hittable, so all-zero doubles as "no object".
  typedef struct packed {
    fp24_vec3    center;
    logic [23:0] radius;
    logic [7:0]  material;
  } object;

  localparam object OBJ_NONE = '0;

  typedef enum logic {
    ST_IDLE,
    ST_PENDING
  } swap_state_e;

endpackage

// File: rtl/scene_bank_ram.sv
// Simple dual-port RAM holding both scene banks, addressed {bank, idx}.
// One registered read stage, no reset on the array or read register so it maps to block RAM.
module scene_bank_ram
  import scene_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        wr_en,
  input  logic [AW:0] wr_addr,
  input  object       wr_dat,
  input  logic [AW:0] rd_addr,
  output object       rd_dat
);

  object mem [2*DEPTH];
  object rd_dat_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
    rd_dat_q <= mem[rd_addr];
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/scene_buffer.sv
// Double-buffered scene store: 2-cycle pipelined object reads from the front bank,
// loader writes into the back bank, banks swap on commit at the next idle frame boundary.
module scene_buffer #(
  parameter int SCENE_BUFFER_DEPTH = scene_buffer_pkg::SCENE_BUFFER_DEPTH,
  parameter int IDX_W              = $clog2(SCENE_BUFFER_DEPTH-1)+1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IDX_W-1:0]       obj_idx,
  output scene_buffer_pkg::object obj,
  output logic                   obj_last,
  input  logic                   wr_valid,
  input  logic [IDX_W-1:0]       wr_idx,
  input  scene_buffer_pkg::object wr_obj,
  output logic                   wr_ready,
  input  logic                   commit,
  input  logic [IDX_W:0]         commit_count,
  input  logic                   frame_idle,
  output logic                   swap_done,
  output logic [IDX_W:0]         front_count
);

  localparam int AW = $clog2(SCENE_BUFFER_DEPTH);
  localparam int CW = IDX_W + 1;

  scene_buffer_pkg::swap_state_e state_q, state_d;
  logic                    front_sel_q, front_sel_d;
  logic [CW-1:0]           count_q [2];
  logic [CW-1:0]           count_d [2];
  logic                    swap_done_q, swap_done_d;
  logic [IDX_W-1:0]        idx_s1_q, idx_s1_d;
  logic                    sel_s1_q, sel_s1_d;
  scene_buffer_pkg::object obj_q, obj_d;
  logic                    obj_last_q, obj_last_d;

  logic                    wr_en;
  logic [CW-1:0]           commit_sat;
  logic [CW-1:0]           rd_count;
  logic [CW-1:0]           idx_s1_ext;
  scene_buffer_pkg::object ram_rdata;

  assign wr_ready   = (state_q == scene_buffer_pkg::ST_IDLE);
  assign wr_en      = wr_valid && wr_ready && (wr_idx < IDX_W'(SCENE_BUFFER_DEPTH));
  assign commit_sat = (commit_count > CW'(SCENE_BUFFER_DEPTH)) ? CW'(SCENE_BUFFER_DEPTH) : commit_count;

  scene_bank_ram #(
    .DEPTH (SCENE_BUFFER_DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr ({~front_sel_q, wr_idx[AW-1:0]}),
    .wr_dat  (wr_obj),
    .rd_addr ({front_sel_q, obj_idx[AW-1:0]}),
    .rd_dat  (ram_rdata)
  );

  // Commit always wins over frame_idle while pending, so the latest count is latched before swapping.
  always_comb begin
    state_d     = state_q;
    front_sel_d = front_sel_q;
    count_d     = count_q;
    swap_done_d = 1'b0;
    case (state_q)
      scene_buffer_pkg::ST_IDLE: begin
        if (commit) begin
          state_d               = scene_buffer_pkg::ST_PENDING;
          count_d[~front_sel_q] = commit_sat;
        end
      end
      scene_buffer_pkg::ST_PENDING: begin
        if (commit) begin
          count_d[~front_sel_q] = commit_sat;
        end else if (frame_idle) begin
          state_d     = scene_buffer_pkg::ST_IDLE;
          front_sel_d = ~front_sel_q;
          swap_done_d = 1'b1;
        end
      end
      default: state_d = scene_buffer_pkg::ST_IDLE;
    endcase
  end

  // Stage 2 judges range against the bank captured in stage 1, not the live front.
  always_comb begin
    idx_s1_d   = obj_idx;
    sel_s1_d   = front_sel_q;
    rd_count   = count_q[sel_s1_q];
    idx_s1_ext = {1'b0, idx_s1_q};
    obj_d      = (idx_s1_ext < rd_count) ? ram_rdata : scene_buffer_pkg::OBJ_NONE;
    obj_last_d = ((idx_s1_ext + CW'(1)) >= rd_count);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= scene_buffer_pkg::ST_IDLE;
      front_sel_q <= 1'b0;
      count_q[0]  <= '0;
      count_q[1]  <= '0;
      swap_done_q <= 1'b0;
      idx_s1_q    <= '0;
      sel_s1_q    <= 1'b0;
      obj_q       <= '0;
      obj_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      front_sel_q <= front_sel_d;
      count_q     <= count_d;
      swap_done_q <= swap_done_d;
      idx_s1_q    <= idx_s1_d;
      sel_s1_q    <= sel_s1_d;
      obj_q       <= obj_d;
      obj_last_q  <= obj_last_d;
    end
  end

  assign obj         = obj_q;
  assign obj_last    = obj_last_q;
  assign swap_done   = swap_done_q;
  assign front_count = count_q[front_sel_q];

endmodule

// File: doc/scene_buffer.md
# scene_buffer

- Responder side of the scene-buffer read interface: returns `object` records to the ray intersector for the `obj_idx` it drives, plus `obj_last` marking the final object of the scene.
- Double-buffered, so the host/loader can write the next scene into a back bank while rays are traced against the front bank.
- Banks swap only at a frame boundary signalled by the pixel scheduler.
- Sits between the scene loader and `ray_tracer`'s `obj_idx`/`obj`/`obj_last` ports.

## Interface

Parameters:
- `SCENE_BUFFER_DEPTH`, default from the shared package (16): objects per bank.
- `IDX_W`, default `$clog2(SCENE_BUFFER_DEPTH-1)+1`: index width, matching the intersector's `obj_idx` port.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `obj_idx`  in  IDX_W  read index from the intersector.
- `obj`  out  object  object at `obj_idx`, two cycles later.
- `obj_last`  out  1  high with `obj` when that index is the last valid object.
- `wr_valid`  in  1  write strobe into the back bank.
- `wr_idx`  in  IDX_W  write address.
- `wr_obj`  in  object  write data.
- `wr_ready`  out  1  back bank accepts writes.
- `commit`  in  1  one-cycle pulse: back bank complete; request swap.
- `commit_count`  in  IDX_W+1  number of valid objects in the back bank, sampled on `commit`.
- `frame_idle`  in  1  high when no ray is in flight; swaps happen only here.
- `swap_done`  out  1  one-cycle pulse, the cycle after a swap.
- `front_count`  out  IDX_W+1  object count of the current front bank.

## Operation

State, all cleared by reset:
- `front_sel`=0.
- `count[0]` = `count[1]` = 0.
- `swap_pending`=0.
- Read pipeline registers = 0.

Read path:
- Stage 1 registers `{front_sel, obj_idx}` and the RAM read.
- Stage 2 registers `obj` and `obj_last`.
- `obj_last` = (idx == `count[front]`-1) or (idx >= `count[front]`).
- An out-of-range idx, including any idx when count is 0, returns an all-zero `object` (non-hittable by package definition) with `obj_last`=1.

Write path:
- `wr_ready` = !`swap_pending`.
- When `wr_valid` && `wr_ready`, `wr_obj` goes to bank `!front_sel` at `wr_idx`.
- Writes while `wr_ready`=0 are dropped.
- A `wr_idx` >= DEPTH is ignored.

Swap FSM has two states, IDLE and PENDING:
- IDLE -> PENDING on `commit`; latches `count[!front_sel]` <= `commit_count`, saturated to DEPTH.
- PENDING -> IDLE on the first cycle with `frame_idle`=1: toggles `front_sel`, and `swap_done` pulses next cycle.
- `commit` while PENDING re-latches the count and stays PENDING.
- `commit` and `frame_idle` in the same IDLE cycle: the swap waits one cycle (PENDING first), so the count is always latched before the swap.
- Reset mid-operation returns to IDLE with bank 0 front and both counts 0; RAM contents are not cleared.

## Timing

- Read latency is exactly 2 cycles and fully pipelined: a new `obj_idx` is accepted every cycle.
- The bank is selected in stage 1, so reads issued before a swap complete from the old front bank.
- `front_count` updates the same edge as `front_sel`.
- `wr_ready` falls the cycle after `commit` and rises the cycle after the swap.
- Reset values of all outputs: `obj`=0, `obj_last`=0, `wr_ready`=1, `swap_done`=0, `front_count`=0.

## Structure

Shared package holds:
- `object` typedef and its zero/non-hittable encoding.
- `fp24_vec3`.
- `SCENE_BUFFER_DEPTH`.

One sub-module, `scene_bank_ram`:
- Simple dual-port, one write port and one read port.
- 2*DEPTH entries of `object`, addressed `{bank, idx}`.
- One registered read stage (BRAM inference).

The swap FSM, counts and `obj_last` compare live in `scene_buffer`.

## Test plan

- Reset, then read idx 0..3 -> `obj`=0 and `obj_last`=1 each, 2 cycles after each idx; `front_count`=0.
- Write 3 objects to idx 0..2, `commit` with count 3, `frame_idle`=1 two cycles later -> `swap_done` pulses; reads of idx 0..2 return the written objects 2 cycles later; `obj_last` is high only on idx 2.
- Back-to-back reads idx 0,1,2,0 on consecutive cycles -> outputs in the same order on consecutive cycles, no bubbles.
- `commit` with `frame_idle`=0 for 20 cycles -> front unchanged, `wr_ready`=0, a `wr_valid` write is dropped; `frame_idle` rises -> swap next cycle.
- Swap while reads are in flight: idx 1 issued the cycle before the swap -> returns the old-bank object.
- Assert `rst`=0 while PENDING -> `front_count`=0, `wr_ready`=1, `swap_done` never pulses.
